pwm_multi_channel: RTL and testbench
====================================

# pwm_multi_channel

Multi-channel PWM generator with a shared, prescaled period counter, edge- or center-aligned counting, per-channel polarity, and double-buffered (shadow) period/duty registers. New settings take effect only at a period boundary, so channels never glitch on reconfiguration. The block drives fan and servo outputs from the system clock and replaces single-channel counters where several phase-locked outputs are required.

## Interface
- `SYS_FREQ`, 125: system clock in MHz; documentation only, no logic depends on it.
- `CH`, 4: number of PWM channels (1–16).
- `W`, 16: period, duty and counter width in bits.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_p`  in  1  reset, synchronous, active-high.
- `enable`  in  1  run/stop for the counter and outputs.
- `load`  in  1  capture `period`, `duty`, `polarity`, `center_mode` and `prescale` into staging.
- `center_mode`  in  1  0 = edge-aligned, 1 = center-aligned.
- `prescale`  in  8  counter advances once every `prescale+1` clk cycles.
- `period`  in  W  counter top value.
- `duty`  in  CH*W  channel i duty is `duty[i*W +: W]`.
- `polarity`  in  CH  1 = channel output inverted.
- `pwm`  out  CH  PWM outputs, registered.
- `period_end`  out  1  one-cycle pulse per completed period.
- `load_ack`  out  1  one-cycle pulse when staging is applied to the active registers.
- `pending`  out  1  staging is holding values not yet applied.

## Operation
- Register sets:
  - Staging: written by `load`.
  - Active: used by the counter and comparators.
  - Active fields: `per_a`, `duty_a[i]`, `pol_a`, `mode_a`, `pre_a`.
- Prescaler:
  - `pre_cnt` counts 0..`pre_a`.
  - `tick` = (`pre_cnt`==`pre_a`) && `enable`; `pre_cnt` wraps to 0 on `tick`.
- Edge mode: `cnt` counts 0..`per_a`, then wraps to 0. Period = `per_a+1` ticks.
- Center mode:
  - `cnt` counts up 0..`per_a`, then down `per_a-1`..1, then back to 0.
  - Period = `2*per_a` ticks.
  - If `per_a`==0, the block behaves as edge mode.
- Boundary: a tick on which `cnt` returns to 0 next.
  - Edge mode: `cnt`==`per_a`.
  - Center mode: direction down and `cnt`==1.
- Compare: `pwm[i]` <= (`cnt` < `duty_a[i]`) ^ `pol_a[i]`, updated every clk cycle.
  - `duty_a[i]`==0 gives constant inactive level.
  - Edge mode: `duty_a[i]` > `per_a` gives constant active level.
  - Center mode: the channel is active on ticks where `cnt` < duty, so the pulse is centred on `cnt`==0.
- `load`=1: staging <= inputs and `pending` <= 1. Back-to-back loads overwrite staging; the last one wins.
- At a boundary with `pending`=1:
  - Active <= staging; `cnt` and `pre_cnt` restart from 0 with direction up.
  - `pending` <= 0 and `load_ack` pulses.
- `load` and boundary in the same cycle:
  - Active takes the old staging contents.
  - Staging takes the new inputs and `pending` stays 1.
  - `load_ack` still pulses.
- `enable`=0:
  - `cnt`, `pre_cnt` and direction are held at 0/up.
  - `pwm` = `pol_a` (inactive level); `period_end` = 0.
  - Any pending staging is applied on the next clk with a `load_ack` pulse, so configuration can be done before enabling.
- Reset values:
  - `pwm`=0, `period_end`=0, `load_ack`=0, `pending`=0.
  - All active and staging fields 0; `cnt`=0, `pre_cnt`=0, direction up.

## Timing
- `pwm` has 1 clk latency from `cnt`: `pwm` at cycle t+1 reflects `cnt` at cycle t.
- `period_end` and `load_ack` are registered. They assert in the cycle after the boundary tick, the same cycle the active values first drive the compare.
- Edge-mode period in clk cycles = (`pre_a`+1)*(`per_a`+1). Center-mode period = (`pre_a`+1)*2*`per_a`.
- Sync reset: `reset_p` is sampled only on the `clk` edge. Asserting it mid-period forces all reset values at that edge, discards pending staging, and takes priority over `load` and `enable`.
- `enable` rising: the first tick occurs `pre_a`+1 cycles later. Counting starts at `cnt`=0.

## Test plan
1. Configure with `enable`=0: load `period`=9, `duty0`=3, `prescale`=0 → `load_ack` 1 cycle later. Raise `enable` → `pwm[0]` high 3 of every 10 cycles, `period_end` every 10 cycles.
2. Load `prescale`=4, `period`=9, `duty0`=5 → `period_end` every 50 cycles, `pwm[0]` high 25 cycles per period.
3. Shadow update: load `duty0`=7 at `cnt`=4 of a `period`=9 run → `pwm[0]` keeps duty 3 until the boundary. `load_ack` coincides with `period_end`, and the next period is high for 7 cycles.
4. Center mode, `period`=8, `duty0`=4, `prescale`=0 → `period_end` every 16 cycles, `pwm[0]` high for 7 contiguous cycles centred on `cnt`=0.
5. Extremes: `duty0`=0 → constant low. `duty1`=10 with `period`=9 → constant high. `polarity`=0b0001 → `pwm[0]` inverted. `enable`=0 → `pwm`=`pol_a`.
6. `reset_p` pulsed 1 cycle mid-period with `pending`=1 → next clk edge gives `pwm`=0, `pending`=0, no `load_ack`. A `reset_p` glitch between clk edges has no effect.

Source files
------------

// File: rtl/pwm_multi_channel_if.sv
// Configuration and output bundle of the multi-channel PWM generator.
// The master side configures the block and observes its outputs; the slave side is the generator itself.
interface pwm_multi_channel_if #(
  parameter int CH = 4,
  parameter int W  = 16
);
  logic              enable;
  logic              load;
  logic              center_mode;
  logic [7:0]        prescale;
  logic [W-1:0]      period;
  logic [CH*W-1:0]   duty;
  logic [CH-1:0]     polarity;
  logic [CH-1:0]     pwm;
  logic              period_end;
  logic              load_ack;
  logic              pending;

  modport master (
    output enable, load, center_mode, prescale, period, duty, polarity,
    input  pwm, period_end, load_ack, pending
  );

  modport slave (
    input  enable, load, center_mode, prescale, period, duty, polarity,
    output pwm, period_end, load_ack, pending
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with a shared prescaled counter (edge or center aligned) and
// shadowed configuration that is only applied at a period boundary or while stopped.
module pwm_multi_channel #(
  parameter int SYS_FREQ = 125,
  parameter int CH       = 4,
  parameter int W        = 16
) (
  input logic                clk,
  input logic                reset_p,
  pwm_multi_channel_if.slave bus
);

  // SYS_FREQ carries no logic; this guard only records that it must be positive.
  if (SYS_FREQ < 1) begin : g_sys_freq_invalid
  end

  logic [W-1:0]  per_s_reg, per_a_reg;
  logic [7:0]    pre_s_reg, pre_a_reg;
  logic          mode_s_reg, mode_a_reg;
  logic [CH-1:0] pol_s_reg, pol_a_reg;

  logic [7:0]    pre_cnt_reg, pre_cnt_next;
  logic [W-1:0]  cnt_reg, cnt_next;
  logic          down_reg, down_next;
  logic          pending_reg, period_end_reg, load_ack_reg;
  logic [CH-1:0] pwm_reg, pwm_next;

  logic center, tick, at_end, boundary, apply;

  always_comb begin
    center = mode_a_reg && (per_a_reg != '0);
    tick   = bus.enable && (pre_cnt_reg == pre_a_reg);
    // In center mode the last count of a period is 1 on the way down, or the top when the top is 1.
    if (center) at_end = (cnt_reg == W'(1)) && (down_reg || per_a_reg == W'(1));
    else        at_end = (cnt_reg == per_a_reg);
    boundary = tick && at_end;
    apply    = pending_reg && (boundary || !bus.enable);

    cnt_next     = cnt_reg;
    down_next    = down_reg;
    pre_cnt_next = pre_cnt_reg + 8'd1;
    if (!bus.enable || apply) begin
      cnt_next     = '0;
      down_next    = 1'b0;
      pre_cnt_next = '0;
    end else if (tick) begin
      pre_cnt_next = '0;
      if (at_end) begin
        cnt_next  = '0;
        down_next = 1'b0;
      end else if (down_reg) begin
        cnt_next = cnt_reg - W'(1);
      end else if (center && cnt_reg == per_a_reg) begin
        cnt_next  = cnt_reg - W'(1);
        down_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + W'(1);
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < CH; gi++) begin : g_ch
    logic [W-1:0] duty_s_reg, duty_a_reg;

    always_ff @(posedge clk) begin
      if (reset_p) begin
        duty_s_reg <= '0;
        duty_a_reg <= '0;
      end else begin
        if (apply)    duty_a_reg <= duty_s_reg;
        if (bus.load) duty_s_reg <= bus.duty[gi*W +: W];
      end
    end

    assign pwm_next[gi] = bus.enable ? ((cnt_reg < duty_a_reg) ^ pol_a_reg[gi]) : pol_a_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      per_s_reg      <= '0;
      per_a_reg      <= '0;
      pre_s_reg      <= '0;
      pre_a_reg      <= '0;
      mode_s_reg     <= 1'b0;
      mode_a_reg     <= 1'b0;
      pol_s_reg      <= '0;
      pol_a_reg      <= '0;
      pre_cnt_reg    <= '0;
      cnt_reg        <= '0;
      down_reg       <= 1'b0;
      pending_reg    <= 1'b0;
      period_end_reg <= 1'b0;
      load_ack_reg   <= 1'b0;
      pwm_reg        <= '0;
    end else begin
      pre_cnt_reg    <= pre_cnt_next;
      cnt_reg        <= cnt_next;
      down_reg       <= down_next;
      period_end_reg <= boundary;
      load_ack_reg   <= apply;
      pwm_reg        <= pwm_next;
      if (apply) begin
        per_a_reg  <= per_s_reg;
        pre_a_reg  <= pre_s_reg;
        mode_a_reg <= mode_s_reg;
        pol_a_reg  <= pol_s_reg;
      end
      // A load coinciding with an apply lands in staging and stays pending.
      if (bus.load) begin
        per_s_reg   <= bus.period;
        pre_s_reg   <= bus.prescale;
        mode_s_reg  <= bus.center_mode;
        pol_s_reg   <= bus.polarity;
        pending_reg <= 1'b1;
      end else if (apply) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign bus.pwm        = pwm_reg;
  assign bus.period_end = period_end_reg;
  assign bus.load_ack   = load_ack_reg;
  assign bus.pending    = pending_reg;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: a time-based reference model feeds a scoreboard queue,
// a monitor compares every cycle, and directed measurements check duty and period counts.
module tb_pwm_multi_channel;
  localparam int CH = 4;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic reset_p;
  always #5 clk = ~clk;

  pwm_multi_channel_if #(.CH(CH), .W(W)) bus ();

  pwm_multi_channel #(.SYS_FREQ(125), .CH(CH), .W(W)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  typedef struct packed {
    logic [W-1:0]           per;
    logic [CH-1:0][W-1:0]   duty;
    logic [CH-1:0]          pol;
    logic                   mode;
    logic [7:0]             pre;
  } cfg_t;

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic          pe;
    logic          ack;
    logic          pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  cfg_t m_act, m_stg;
  bit   m_pend;
  int   m_t;

  // Reference model: the counter value is derived from the cycles elapsed since counting
  // (re)started, using the period length and triangle shape directly.
  always @(posedge clk) begin : model
    int   per, pre, plen, p, cnt;
    bit   center, tick, bnd, apply;
    exp_t e;
    e = '0;
    if (reset_p) begin
      m_act  = '0;
      m_stg  = '0;
      m_pend = 1'b0;
      m_t    = 0;
    end else begin
      per    = int'(m_act.per);
      pre    = int'(m_act.pre);
      center = m_act.mode && (per != 0);
      plen   = center ? 2 * per : per + 1;
      tick   = bus.enable && ((m_t % (pre + 1)) == pre);
      p      = (m_t / (pre + 1)) % plen;
      cnt    = (center && p > per) ? 2 * per - p : p;
      bnd    = tick && (p == plen - 1);
      for (int c = 0; c < CH; c++)
        e.pwm[c] = bus.enable ? ((cnt < int'(m_act.duty[c])) ^ m_act.pol[c]) : m_act.pol[c];
      apply = m_pend && (bnd || !bus.enable);
      e.pe  = bnd;
      e.ack = apply;
      if (apply) m_act = m_stg;
      if (bus.load) begin
        m_stg.per  = bus.period;
        m_stg.duty = bus.duty;
        m_stg.pol  = bus.polarity;
        m_stg.mode = bus.center_mode;
        m_stg.pre  = bus.prescale;
        m_pend     = 1'b1;
      end else if (apply) begin
        m_pend = 1'b0;
      end
      e.pend = m_pend;
      m_t    = (!bus.enable || apply) ? 0 : m_t + 1;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {bus.pwm, bus.period_end, bus.load_ack, bus.pending};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scoreboard @%0t: got pwm=%b pe=%b ack=%b pend=%b, want pwm=%b pe=%b ack=%b pend=%b",
                 $time, got.pwm, got.pe, got.ack, got.pend, e.pwm, e.pe, e.ack, e.pend);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic cfg_t mk(input int per, input int d0, input int d1, input int d2, input int d3,
                              input logic [CH-1:0] pol, input logic mode, input int pre);
    cfg_t c;
    c.per     = W'(per);
    c.duty[0] = W'(d0);
    c.duty[1] = W'(d1);
    c.duty[2] = W'(d2);
    c.duty[3] = W'(d3);
    c.pol     = pol;
    c.mode    = mode;
    c.pre     = 8'(pre);
    return c;
  endfunction

  task automatic do_load(input cfg_t c);
    @(negedge clk);
    bus.period      = c.per;
    bus.duty        = c.duty;
    bus.polarity    = c.pol;
    bus.center_mode = c.mode;
    bus.prescale    = c.pre;
    bus.load        = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_for(input string name, input bit use_ack, input int limit);
    int n;
    n = 0;
    checks++;
    do begin
      @(negedge clk);
      n++;
    end while (!(use_ack ? bus.load_ack : bus.period_end) && n < limit);
    if (!(use_ack ? bus.load_ack : bus.period_end)) begin
      errors++;
      $display("FAIL %s: no pulse within %0d cycles", name, limit);
    end
  endtask

  task automatic measure(input int n, output int hi0, output int hi1, output int hi2,
                         output int pe, output int run0);
    int run;
    run = 0; hi0 = 0; hi1 = 0; hi2 = 0; pe = 0; run0 = 0;
    repeat (n) begin
      @(negedge clk);
      hi0 += int'(bus.pwm[0]);
      hi1 += int'(bus.pwm[1]);
      hi2 += int'(bus.pwm[2]);
      pe  += int'(bus.period_end);
      if (bus.pwm[0]) begin
        run++;
        if (run > run0) run0 = run;
      end else begin
        run = 0;
      end
    end
  endtask

  initial begin : stim
    int hi0, hi1, hi2, pe, run0, acks, r, p;
    reset_p         = 1'b1;
    bus.enable      = 1'b0;
    bus.load        = 1'b0;
    bus.center_mode = 1'b0;
    bus.prescale    = '0;
    bus.period      = '0;
    bus.duty        = '0;
    bus.polarity    = '0;
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(bus.pwm), 0);
    check("reset_pending", int'(bus.pending), 0);
    reset_p = 1'b0;

    // Configure while stopped, then run edge-aligned period 9, duty 3.
    do_load(mk(9, 3, 0, 0, 0, 4'b0000, 1'b0, 0));
    check("t1_pending", int'(bus.pending), 1);
    @(negedge clk);
    check("t1_load_ack", int'(bus.load_ack), 1);
    bus.enable = 1'b1;
    repeat (12) @(negedge clk);
    measure(30, hi0, hi1, hi2, pe, run0);
    check("t1_high_cycles", hi0, 9);
    check("t1_period_ends", pe, 3);

    // Prescale 4: period 50 clk, 25 high.
    do_load(mk(9, 5, 0, 0, 0, 4'b0000, 1'b0, 4));
    wait_for("t2_ack", 1'b1, 100);
    measure(100, hi0, hi1, hi2, pe, run0);
    check("t2_high_cycles", hi0, 50);
    check("t2_period_ends", pe, 2);

    // Shadow update mid-period.
    do_load(mk(9, 3, 0, 0, 0, 4'b0000, 1'b0, 0));
    wait_for("t3_ack_setup", 1'b1, 100);
    wait_for("t3_period_end", 1'b0, 20);
    repeat (3) @(negedge clk);
    do_load(mk(9, 7, 0, 0, 0, 4'b0000, 1'b0, 0));
    check("t3_old_duty_kept", int'(bus.pwm[0]), 0);
    check("t3_pending", int'(bus.pending), 1);
    wait_for("t3_ack", 1'b1, 20);
    check("t3_ack_with_period_end", int'(bus.period_end), 1);
    measure(10, hi0, hi1, hi2, pe, run0);
    check("t3_new_high_cycles", hi0, 7);

    // Center mode period 8, duty 4.
    do_load(mk(8, 4, 0, 0, 0, 4'b0000, 1'b1, 0));
    wait_for("t4_ack", 1'b1, 30);
    measure(32, hi0, hi1, hi2, pe, run0);
    check("t4_period_ends", pe, 2);
    check("t4_high_cycles", hi0, 14);
    check("t4_contiguous_run", run0, 7);

    // Extremes and polarity.
    do_load(mk(9, 0, 10, 5, 9, 4'b0001, 1'b0, 0));
    wait_for("t5_ack", 1'b1, 40);
    measure(30, hi0, hi1, hi2, pe, run0);
    check("t5_duty0_inverted", hi0, 30);
    check("t5_duty_over_period", hi1, 30);
    check("t5_duty_half", hi2, 15);
    bus.enable = 1'b0;
    @(negedge clk);
    check("t5_disabled_pwm", int'(bus.pwm), 1);
    check("t5_disabled_pe", int'(bus.period_end), 0);

    // Reset glitch between edges, then a real reset with staging pending.
    bus.enable = 1'b1;
    do_load(mk(100, 30, 0, 0, 0, 4'b0000, 1'b0, 0));
    wait_for("t6_ack_long", 1'b1, 30);
    do_load(mk(9, 3, 0, 0, 0, 4'b0000, 1'b0, 0));
    check("t6_pending", int'(bus.pending), 1);
    @(posedge clk);
    #2 reset_p = 1'b1;
    #2 reset_p = 1'b0;
    @(negedge clk);
    check("t6_glitch_ignored", int'(bus.pending), 1);
    reset_p = 1'b1;
    @(negedge clk);
    reset_p = 1'b0;
    check("t6_reset_pwm", int'(bus.pwm), 0);
    check("t6_reset_pending", int'(bus.pending), 0);
    check("t6_reset_ack", int'(bus.load_ack), 0);
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      acks += int'(bus.load_ack);
    end
    check("t6_no_ack_after_reset", acks, 0);

    // Randomized traffic checked by the scoreboard.
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        p = int'($urandom_range(0, 12));
        do_load(mk(p, int'($urandom_range(0, p + 2)), int'($urandom_range(0, p + 2)),
                   int'($urandom_range(0, p + 2)), int'($urandom_range(0, p + 2)),
                   4'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3))));
      end else if (r < 7) begin
        @(negedge clk);
        bus.enable = ~bus.enable;
      end else if (r == 7) begin
        @(negedge clk);
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
      end
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
